iir_biquad_mc: RTL and testbench

IIR_BIQUAD_MC -- requirements
Module: iir_biquad_mc

---
 rtl/iir_pkg.sv | 20 ++
 rtl/iir_mac.sv | 35 +++
 rtl/iir_biquad_mc.sv | 215 +++++++++++++++++++++
 tb/tb_iir_biquad_mc.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared constants for the multi-channel biquad: coefficient slot indices,
// controller states and the default coefficient fraction width.
package iir_pkg;

    localparam int unsigned DEFAULT_FRAC = 14;
    localparam int unsigned NCOEF        = 5;

    localparam int unsigned B0 = 0;
    localparam int unsigned B1 = 1;
    localparam int unsigned B2 = 2;
    localparam int unsigned A1 = 3;
    localparam int unsigned A2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/iir_mac.sv
// Shared signed multiplier feeding an accumulator register with
// clear / accumulate / subtract controls; exposes the next accumulator value.
module iir_mac #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 2 * WIDTH + 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    sub_i,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic signed [WIDTH-1:0] coef_i,
    output logic signed [ACC_W-1:0] acc_next_c
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   base;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod       = data_i * coef_i;
    assign prod_ext   = {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
    assign base       = clr_i ? '0 : acc_q;
    assign acc_next_c = sub_i ? (base - prod_ext) : (base + prod_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_next_c;
        end
    end

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel direct-form-I biquad with one time-shared multiplier.
// Define IIR_BIQUAD_SAT_EN to saturate results; otherwise results wrap.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CH    = 4,
    parameter int unsigned FRAC  = DEFAULT_FRAC,
    localparam int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CHW-1:0]   in_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CHW-1:0]   out_ch,
    input  logic             coef_we,
    input  logic [2:0]       coef_addr,
    input  logic [WIDTH-1:0] coef_data
);

    localparam int unsigned ACC_W = 2 * WIDTH + 3;
    localparam logic signed [WIDTH-1:0] COEF_ONE = WIDTH'(1 << FRAC);

    state_e                  state_q, state_d;
    logic [2:0]              step_q, step_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic [CHW-1:0]          out_ch_q, out_ch_d;

    logic signed [WIDTH-1:0] pend_q [NCOEF];
    logic signed [WIDTH-1:0] pend_d [NCOEF];
    logic signed [WIDTH-1:0] act_q  [NCOEF];
    logic signed [WIDTH-1:0] act_d  [NCOEF];

    logic signed [WIDTH-1:0] x1_q [CH];
    logic signed [WIDTH-1:0] x1_d [CH];
    logic signed [WIDTH-1:0] x2_q [CH];
    logic signed [WIDTH-1:0] x2_d [CH];
    logic signed [WIDTH-1:0] y1_q [CH];
    logic signed [WIDTH-1:0] y1_d [CH];
    logic signed [WIDTH-1:0] y2_q [CH];
    logic signed [WIDTH-1:0] y2_d [CH];

    logic                    mac_en, mac_clr, mac_sub;
    logic signed [WIDTH-1:0] mac_data, mac_coef;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [WIDTH-1:0] y_red;

    iir_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .en_i       (mac_en),
        .clr_i      (mac_clr),
        .sub_i      (mac_sub),
        .data_i     (mac_data),
        .coef_i     (mac_coef),
        .acc_next_c (acc_next)
    );

    // Scale the final sum back to sample format.
`ifdef IIR_BIQUAD_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_next >>> FRAC;

    always_comb begin
        if (shifted > Y_MAX) begin
            y_red = Y_MAX[WIDTH-1:0];
        end else if (shifted < Y_MIN) begin
            y_red = Y_MIN[WIDTH-1:0];
        end else begin
            y_red = shifted[WIDTH-1:0];
        end
    end
`else
    assign y_red = WIDTH'(acc_next >>> FRAC);
`endif

    // Next-state, datapath control and history/bank updates.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        x_d         = x_q;
        ch_d        = ch_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        pend_d      = pend_q;
        act_d       = act_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        mac_sub     = 1'b0;
        mac_data    = '0;
        mac_coef    = '0;

        if (coef_we && (coef_addr < 3'(NCOEF))) begin
            pend_d[coef_addr] = coef_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    act_d = pend_d;
                    if (32'(in_ch) < CH) begin
                        x_d        = in_data;
                        ch_d       = in_ch;
                        step_d     = '0;
                        in_ready_d = 1'b0;
                        state_d    = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                mac_en   = 1'b1;
                mac_clr  = (step_q == 3'(B0));
                mac_sub  = (step_q >= 3'(A1));
                mac_coef = act_q[step_q];
                case (step_q)
                    3'(B0):  mac_data = x_q;
                    3'(B1):  mac_data = x1_q[ch_q];
                    3'(B2):  mac_data = x2_q[ch_q];
                    3'(A1):  mac_data = y1_q[ch_q];
                    default: mac_data = y2_q[ch_q];
                endcase
                step_d = step_q + 3'd1;
                if (step_q == 3'(A2)) begin
                    x2_d[ch_q]  = x1_q[ch_q];
                    x1_d[ch_q]  = x_q;
                    y2_d[ch_q]  = y1_q[ch_q];
                    y1_d[ch_q]  = y_red;
                    out_valid_d = 1'b1;
                    out_data_d  = y_red;
                    out_ch_d    = ch_q;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            x_q         <= '0;
            ch_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int unsigned i = 0; i < NCOEF; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            pend_q[B0] <= COEF_ONE;
            act_q[B0]  <= COEF_ONE;
            for (int unsigned i = 0; i < CH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            x_q         <= x_d;
            ch_q        <= ch_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: main instance with CH=4 and a CH=3
// instance whose out-of-range channel index is representable on the port.
module tb_iir_biquad_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_valid_b;
    logic        in_ready, in_ready_b;
    logic [15:0] in_data;
    logic [1:0]  in_ch;
    logic        out_valid, out_valid_b;
    logic        out_ready;
    logic [15:0] out_data, out_data_b;
    logic [1:0]  out_ch, out_ch_b;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;

    int n_vec = 0;
    int n_err = 0;

`ifdef IIR_BIQUAD_SAT_EN
    localparam logic [15:0] EXP_POS = 16'h7FFF;
    localparam logic [15:0] EXP_NEG = 16'h8000;
`else
    localparam logic [15:0] EXP_POS = 16'hFFFC;
    localparam logic [15:0] EXP_NEG = 16'h0002;
`endif

    localparam logic [1:0]  SEQ_CH [7] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    localparam logic [15:0] SEQ_X  [7] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000,
                                           16'h0000, 16'h0000, 16'h0000};
    localparam logic [15:0] SEQ_Y  [7] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000,
                                           16'h1000, 16'h0000, 16'h0800};

    always #5 clk = ~clk;

    iir_biquad_mc #(.WIDTH(16), .CH(4), .FRAC(14)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    iir_biquad_mc #(.WIDTH(16), .CH(3), .FRAC(14)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .out_ch    (out_ch_b),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    task automatic do_reset();
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        out_ready  = 1'b1;
        in_data    = '0;
        in_ch      = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_data  = '0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Present a sample at a falling edge; returns one falling edge after acceptance.
    task automatic send(input bit to_b, input logic [1:0] ch, input logic [15:0] data);
        in_ch   = ch;
        in_data = data;
        if (to_b) in_valid_b = 1'b1;
        else      in_valid   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (to_b ? in_ready_b : in_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic recv(input bit from_b, output logic [15:0] data, output logic [1:0] ch);
        data = 'x;
        ch   = 'x;
        for (int i = 0; i < 40; i++) begin
            if (from_b ? out_valid_b : out_valid) begin
                data = from_b ? out_data_b : out_data;
                ch   = from_b ? out_ch_b : out_ch;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [15:0] data);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (out_data !== 16'h0000) begin n_err++; $display("FAIL rst_out_data: got %h expected 0000", out_data); end
        n_vec++;
        if (out_ch !== 2'd0) begin n_err++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_passthrough();
        logic [15:0] d;
        logic [1:0]  c;
        int          lat;
        do_reset();
        send(1'b0, 2'd0, 16'h1234);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != 6) begin n_err++; $display("FAIL pass_latency: got %0d expected 6", lat); end
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h1234) begin n_err++; $display("FAIL pass_data: got %h expected 1234", d); end
        n_vec++;
        if (c !== 2'd0) begin n_err++; $display("FAIL pass_ch: got %0d expected 0", c); end
        send(1'b0, 2'd2, 16'h8001);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h8001 || c !== 2'd2) begin
            n_err++; $display("FAIL pass_neg: got %h/ch%0d expected 8001/ch2", d, c);
        end
    endtask

    task automatic test_coef_bank();
        logic [15:0] d;
        logic [1:0]  c;
        do_reset();
        write_coef(3'd0, 16'h2000);
        send(1'b0, 2'd0, 16'h4000);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h2000) begin n_err++; $display("FAIL coef_half: got %h expected 2000", d); end
        send(1'b0, 2'd0, 16'h4000);
        write_coef(3'd0, 16'h4000);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h2000) begin n_err++; $display("FAIL coef_inflight: got %h expected 2000", d); end
        send(1'b0, 2'd0, 16'h4000);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h4000) begin n_err++; $display("FAIL coef_applied: got %h expected 4000", d); end
        in_ch    = 2'd0;
        in_data  = 16'h4000;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        coef_we  = 1'b0;
        in_valid = 1'b0;
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h1000) begin n_err++; $display("FAIL coef_coincident: got %h expected 1000", d); end
        write_coef(3'd5, 16'h7FFF);
        send(1'b0, 2'd0, 16'h4000);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h1000) begin n_err++; $display("FAIL coef_addr5_ignored: got %h expected 1000", d); end
    endtask

    task automatic test_interleave();
        logic [15:0] d;
        logic [1:0]  c;
        do_reset();
        write_coef(3'd0, 16'h4000);
        write_coef(3'd3, 16'hE000);
        for (int k = 0; k < 7; k++) begin
            send(1'b0, SEQ_CH[k], SEQ_X[k]);
            recv(1'b0, d, c);
            n_vec++;
            if (d !== SEQ_Y[k] || c !== SEQ_CH[k]) begin
                n_err++;
                $display("FAIL interleave[%0d]: got %h/ch%0d expected %h/ch%0d", k, d, c, SEQ_Y[k], SEQ_CH[k]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] d;
        logic [1:0]  c;
        do_reset();
        write_coef(3'd0, 16'h7FFF);
        send(1'b0, 2'd0, 16'h7FFF);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== EXP_POS) begin n_err++; $display("FAIL sat_pos: got %h expected %h", d, EXP_POS); end
        send(1'b0, 2'd0, 16'h8000);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== EXP_NEG) begin n_err++; $display("FAIL sat_neg: got %h expected %h", d, EXP_NEG); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic [1:0]  c;
        do_reset();
        out_ready = 1'b0;
        send(1'b0, 2'd1, 16'h0111);
        recv(1'b0, d, c);
        in_ch    = 2'd0;
        in_data  = 16'h0222;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 16'h0111 || out_ch !== 2'd1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall[%0d]: got v%b %h/ch%0d rdy%b expected v1 0111/ch1 rdy0",
                         i, out_valid, out_data, out_ch, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL after_xfer: got v%b rdy%b expected v0 rdy1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h0222 || c !== 2'd0) begin
            n_err++; $display("FAIL second_sample: got %h/ch%0d expected 0222/ch0", d, c);
        end
    endtask

    task automatic test_bad_channel();
        logic [15:0] d;
        logic [1:0]  c;
        bit          seen_valid;
        bit          ready_low;
        do_reset();
        write_coef(3'd1, 16'h4000);
        send(1'b1, 2'd0, 16'h0100);
        recv(1'b1, d, c);
        n_vec++;
        if (d !== 16'h0100) begin n_err++; $display("FAIL badch_first: got %h expected 0100", d); end
        send(1'b1, 2'd3, 16'h1000);
        seen_valid = 1'b0;
        ready_low  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_b) seen_valid = 1'b1;
            if (!in_ready_b) ready_low = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (seen_valid || ready_low) begin
            n_err++; $display("FAIL badch_discard: got valid%b ready_low%b expected 0 0", seen_valid, ready_low);
        end
        send(1'b1, 2'd0, 16'h0200);
        recv(1'b1, d, c);
        n_vec++;
        if (d !== 16'h0300) begin n_err++; $display("FAIL badch_history: got %h expected 0300", d); end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] d;
        logic [1:0]  c;
        bit          seen_valid;
        do_reset();
        write_coef(3'd1, 16'h4000);
        send(1'b0, 2'd0, 16'h1000);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h1000) begin n_err++; $display("FAIL pre_abort: got %h expected 1000", d); end
        send(1'b0, 2'd0, 16'h0800);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        n_vec++;
        if (seen_valid) begin n_err++; $display("FAIL abort_no_output: got valid 1 expected 0"); end
        send(1'b0, 2'd1, 16'h0100);
        recv(1'b0, d, c);
        send(1'b0, 2'd1, 16'h0200);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h0200) begin n_err++; $display("FAIL abort_coef_restored: got %h expected 0200", d); end
        write_coef(3'd1, 16'h4000);
        send(1'b0, 2'd0, 16'h0100);
        recv(1'b0, d, c);
        n_vec++;
        if (d !== 16'h0100) begin n_err++; $display("FAIL abort_history_cleared: got %h expected 0100", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_passthrough();
        test_coef_bank();
        test_interleave();
        test_saturate();
        test_backpressure();
        test_bad_channel();
        test_reset_mid_mac();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
